// File: rtl/sbox_share_sched.sv
// sbox_share_sched: time-shares one pipelined S-box between the key-schedule
// requester (K) and the round-datapath requester (R). A granted 32-bit word is
// issued one byte per cycle, results are collected in issue order, and the
// substituted word is returned with a done pulse to the owning side.
module sbox_share_sched #(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_k_req,
    input  logic [31:0] i_k_word,
    output logic        o_k_ack,
    output logic        o_k_done,
    input  logic        i_r_req,
    input  logic [31:0] i_r_word,
    output logic        o_r_ack,
    output logic        o_r_done,
    output logic [31:0] o_result,
    output logic        o_busy,
    output logic [7:0]  o_sbox_a,
    output logic        o_sbox_v,
    input  logic [7:0]  i_sbox_z
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

    state_t               r_state;
    state_t               w_state_d;
    logic [1:0]           r_byte_idx;
    logic [1:0]           r_cap_idx;
    logic [SBOX_LAT-1:0]  r_vpipe;
    logic [31:0]          r_word;
    logic [23:0]          r_acc;
    logic [31:0]          r_result;
    logic                 r_owner;     // 1: R side owns the word in flight
    logic                 r_last_gnt;  // 1: R side got the most recent grant

    logic                 w_grant;
    logic                 w_grant_r;
    logic                 w_k_ack;
    logic                 w_r_ack;
    logic                 w_cap;
    logic                 w_last_cap;

    // Tap of the valid pipe marks the cycle a result sits on SBOX_Z.
    assign w_cap      = r_vpipe[SBOX_LAT-1];
    assign w_last_cap = w_cap && (r_cap_idx == 2'd3);

    // Arbitration and next-state decode.
    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        w_grant_r = 1'b0;
        w_k_ack   = 1'b0;
        w_r_ack   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Acks stay low while reset is held so every output reads 0.
                if (!i_rst) begin
                    if (i_k_req && (!i_r_req || r_last_gnt)) begin
                        w_k_ack = 1'b1;
                        w_grant = 1'b1;
                    end else if (i_r_req) begin
                        w_r_ack   = 1'b1;
                        w_grant   = 1'b1;
                        w_grant_r = 1'b1;
                    end
                end
                if (w_grant) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (r_byte_idx == 2'd3) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_last_cap) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Grant bookkeeping: latched word, owner and round-robin history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word     <= 32'd0;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
        end else if (w_grant) begin
            r_word     <= w_grant_r ? i_r_word : i_k_word;
            r_owner    <= w_grant_r;
            r_last_gnt <= w_grant_r;
        end
    end

    // Issue byte counter; wraps back to 0 after byte 3.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_byte_idx <= 2'd0;
        end else if (r_state == StIssue) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end else begin
            r_byte_idx <= 2'd0;
        end
    end

    // Valid pipe mirrors the S-box latency so results are captured on time.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vpipe <= '0;
        end else begin
            for (int i = SBOX_LAT - 1; i > 0; i--) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_vpipe[0] <= o_sbox_v;
        end
    end

    // Capture lanes 0..2; lane 3 goes straight into the result register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cap_idx <= 2'd0;
            r_acc     <= 24'd0;
        end else if (w_cap) begin
            r_cap_idx <= r_cap_idx + 2'd1;
            case (r_cap_idx)
                2'd0:    r_acc[7:0]   <= i_sbox_z;
                2'd1:    r_acc[15:8]  <= i_sbox_z;
                2'd2:    r_acc[23:16] <= i_sbox_z;
                default: r_acc        <= r_acc;
            endcase
        end
    end

    // Result loads on the edge entering DONE so it is valid with the pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_result <= 32'd0;
        end else if ((r_state == StDrain) && w_last_cap) begin
            r_result <= {i_sbox_z, r_acc};
        end
    end

    // Output decode.
    always_comb begin
        o_k_ack  = w_k_ack;
        o_r_ack  = w_r_ack;
        o_k_done = (r_state == StDone) && !r_owner;
        o_r_done = (r_state == StDone) && r_owner;
        o_result = r_result;
        o_busy   = (r_state != StIdle);
        o_sbox_v = (r_state == StIssue);
        o_sbox_a = o_sbox_v ? r_word[{r_byte_idx, 3'b000} +: 8] : 8'd0;
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench for sbox_share_sched: three instances at S-box latencies
// 1, 2 and 4, each fed by a behavioural S-box with the matching delay.
module tb_sbox_share_sched;

    logic             clk;
    logic             rst;
    logic [2:0]       k_req;
    logic [2:0]       r_req;
    logic [2:0][31:0] k_word;
    logic [2:0][31:0] r_word;
    logic [2:0]       k_ack;
    logic [2:0]       r_ack;
    logic [2:0]       k_done;
    logic [2:0]       r_done;
    logic [2:0][31:0] result;
    logic [2:0]       busy;
    logic [2:0][7:0]  sbox_a;
    logic [2:0]       sbox_v;

    int n_total = 0;
    int n_bad   = 0;

    // AES S-box values for the bytes used here; anything else gets a marker.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        case (x)
            8'h00:   return 8'h63;
            8'h01:   return 8'h7C;
            8'h53:   return 8'hED;
            8'hFF:   return 8'h16;
            default: return x ^ 8'hA5;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [7:0] apipe [LAT];
        logic       vpipe [LAT];
        logic [7:0] z;

        always @(posedge clk) begin
            for (int i = LAT - 1; i > 0; i--) begin
                apipe[i] <= apipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
            apipe[0] <= sbox_a[g];
            vpipe[0] <= sbox_v[g];
        end

        assign z = (vpipe[LAT-1] === 1'b1) ? aes_sbox(apipe[LAT-1]) : 8'h5A;

        sbox_share_sched #(
            .SBOX_LAT(LAT)
        ) u_dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_k_req  (k_req[g]),
            .i_k_word (k_word[g]),
            .o_k_ack  (k_ack[g]),
            .o_k_done (k_done[g]),
            .i_r_req  (r_req[g]),
            .i_r_word (r_word[g]),
            .o_r_ack  (r_ack[g]),
            .o_r_done (r_done[g]),
            .o_result (result[g]),
            .o_busy   (busy[g]),
            .o_sbox_a (sbox_a[g]),
            .o_sbox_v (sbox_v[g]),
            .i_sbox_z (z)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int d, input bit side_r);
        return side_r ? r_ack[d] : k_ack[d];
    endfunction

    function automatic logic done_of(input int d, input bit side_r);
        return side_r ? r_done[d] : k_done[d];
    endfunction

    // Request one word on one side, then check latency and the returned word.
    task automatic do_word(input int d, input bit side_r, input logic [31:0] w,
                           input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        if (side_r) begin
            r_req[d]  = 1'b1;
            r_word[d] = w;
        end else begin
            k_req[d]  = 1'b1;
            k_word[d] = w;
        end
        #1;
        n = 0;
        while (!ack_of(d, side_r) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ack_wait", n, 0);
        @(negedge clk);
        k_req[d] = 1'b0;
        r_req[d] = 1'b0;
        #1;
        n = 1;
        while (!done_of(d, side_r) && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_lat", n, 5 + lat);
        chk("done_res", result[d], exp);
        chk("other_done", done_of(d, !side_r), 1'b0);
    endtask

    initial begin
        int         n;
        int         m;
        bit         flag;
        logic [31:0] exp_a;

        rst    = 1'b1;
        k_req  = '0;
        r_req  = '0;
        k_word = '0;
        r_word = '0;

        // Reset state and quiet idle.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_outs", {24'd0, k_ack[1], r_ack[1], k_done[1], r_done[1], busy[1],
                         sbox_v[1], 2'b00}, 32'd0);
        chk("rst_sbox_a", sbox_a[1], 8'd0);
        chk("rst_result", result[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((|busy) || (|sbox_v) || (|k_ack) || (|r_ack)) flag = 1'b1;
            @(negedge clk);
        end
        chk("idle_quiet", flag, 1'b0);

        // Single K word on the latency-2 instance, cycle by cycle.
        k_req[1]  = 1'b1;
        k_word[1] = 32'h00010053;
        #1;
        chk("k_ack_t0", k_ack[1], 1'b1);
        chk("busy_t0", busy[1], 1'b0);
        exp_a = 32'h00010053;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            k_req[1] = 1'b0;
            #1;
            chk("sbox_a", sbox_a[1], exp_a[8*i +: 8]);
            chk("sbox_v", sbox_v[1], 1'b1);
        end
        @(negedge clk);
        #1;
        chk("drain_v", sbox_v[1], 1'b0);
        chk("drain_a", sbox_a[1], 8'd0);
        chk("k_done_t5", k_done[1], 1'b0);
        @(negedge clk);
        #1;
        chk("k_done_t6", k_done[1], 1'b0);
        @(negedge clk);
        #1;
        chk("k_done_t7", k_done[1], 1'b1);
        chk("k_res_t7", result[1], 32'h637C63ED);
        chk("r_done_t7", r_done[1], 1'b0);
        @(negedge clk);
        #1;
        chk("k_done_t8", k_done[1], 1'b0);
        chk("busy_t8", busy[1], 1'b0);
        chk("hold_res", result[1], 32'h637C63ED);

        // Both requesting from reset: K first, then strict alternation.
        @(negedge clk);
        rst       = 1'b1;
        k_req[1]  = 1'b1;
        r_req[1]  = 1'b1;
        k_word[1] = 32'hFFFFFFFF;
        r_word[1] = 32'h00000000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(k_ack[1] || r_ack[1]) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_gap", n, (g == 0) ? 0 : 1);
            chk("rr_ack_side", {r_ack[1], k_ack[1]}, (g % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            #1;
            m = 1;
            while (!(k_done[1] || r_done[1]) && m < 30) begin
                @(negedge clk);
                #1;
                m++;
            end
            chk("rr_lat", m, 7);
            chk("rr_done_side", {r_done[1], k_done[1]}, (g % 2 == 1) ? 2'b10 : 2'b01);
            chk("rr_res", result[1], (g % 2 == 1) ? 32'h63636363 : 32'h16161616);
        end
        k_req[1] = 1'b0;
        r_req[1] = 1'b0;

        // R in flight, K raised mid-issue: no preemption.
        @(negedge clk);
        r_req[1]  = 1'b1;
        r_word[1] = 32'h53535353;
        #1;
        chk("np_r_ack", r_ack[1], 1'b1);
        @(negedge clk);
        r_req[1] = 1'b0;
        @(negedge clk);
        k_req[1]  = 1'b1;
        k_word[1] = 32'h00000000;
        #1;
        flag = 1'b0;
        n = 0;
        while (!r_done[1] && n < 20) begin
            if (k_ack[1]) flag = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        if (k_ack[1]) flag = 1'b1;
        chk("np_no_preempt", flag, 1'b0);
        chk("np_r_done", r_done[1], 1'b1);
        chk("np_r_res", result[1], 32'hEDEDEDED);
        @(negedge clk);
        #1;
        chk("np_k_ack", k_ack[1], 1'b1);
        @(negedge clk);
        k_req[1] = 1'b0;
        #1;
        m = 1;
        while (!k_done[1] && m < 30) begin
            @(negedge clk);
            #1;
            m++;
        end
        chk("np_k_lat", m, 7);
        chk("np_k_res", result[1], 32'h63636363);

        // Reset during DRAIN of a K word aborts it.
        @(negedge clk);
        k_req[1]  = 1'b1;
        k_word[1] = 32'h00010053;
        #1;
        chk("ab_ack", k_ack[1], 1'b1);
        @(negedge clk);
        k_req[1] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("ab_in_drain", {busy[1], sbox_v[1]}, 2'b10);
        rst = 1'b1;
        #1;
        chk("ab_result", result[1], 32'd0);
        chk("ab_busy", busy[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (k_done[1] || r_done[1] || busy[1]) flag = 1'b1;
            @(negedge clk);
        end
        chk("ab_no_done", flag, 1'b0);
        chk("ab_result_hold", result[1], 32'd0);
        do_word(1, 1'b0, 32'h00010053, 32'h637C63ED, 2);

        // Latency sweep.
        do_word(0, 1'b0, 32'h53535353, 32'hEDEDEDED, 1);
        do_word(2, 1'b1, 32'h53535353, 32'hEDEDEDED, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-shares one pipelined composite-field S-box between two requesters:
  - K: key-expansion SubWord.
  - R: round-datapath SubBytes column word.
- The S-box is the input affine, GF inversion and output-affine chain. It sits outside this block.
- The block serialises each granted 32-bit word into 4 byte issues, collects the S-box results and returns the substituted word with a done pulse.
- It sits between the AES control FSM and the shared S-box instance.

Parameters:
- SBOX_LAT, 2, cycles from a byte on SBOX_A (registered with SBOX_V) to its result on SBOX_Z. Legal range 1..4.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- K_REQ  input  1  key-schedule request; held until K_ACK.
- K_WORD  input  32  key word to substitute; sampled in the K_ACK cycle.
- K_ACK  output  1  one-cycle pulse: K word accepted.
- K_DONE  output  1  one-cycle pulse: RESULT holds the substituted K word.
- R_REQ  input  1  round request; held until R_ACK.
- R_WORD  input  32  column word; sampled in the R_ACK cycle.
- R_ACK  output  1  one-cycle pulse: R word accepted.
- R_DONE  output  1  one-cycle pulse: RESULT holds the substituted R word.
- RESULT  output  32  substituted word; registered, holds until the next done.
- BUSY  output  1  high in every state except IDLE.
- SBOX_A  output  8  byte to the shared S-box.
- SBOX_V  output  1  SBOX_A is valid this cycle.
- SBOX_Z  input  8  S-box result, SBOX_LAT cycles after issue.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - All outputs 0: K_ACK, R_ACK, K_DONE, R_DONE, RESULT, BUSY, SBOX_A, SBOX_V.
  - Byte counter, capture counter and valid pipe cleared.
  - LAST_GNT=R, so K wins the first tie.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the side not equal to LAST_GNT (round-robin).
  - Grant cycle: pulse that side's ACK, latch its WORD, set OWNER and LAST_GNT, go to ISSUE.
  - No requests: stay in IDLE.
- ISSUE (exactly 4 cycles, byte index i=0..3):
  - SBOX_A = latched word[8i+7:8i], SBOX_V=1.
  - After i=3, go to DRAIN.
- Capture:
  - An SBOX_LAT-deep shift register carries SBOX_V forward.
  - When its tap is high, SBOX_Z is written into result byte lane c, and c increments.
  - Bytes return in issue order: byte 0 lands in bits 7:0.
- DRAIN:
  - SBOX_V=0.
  - When the 4th byte is captured, go to DONE in the next cycle.
- DONE (1 cycle):
  - RESULT updated with the assembled word.
  - OWNER's DONE pulses.
  - Return to IDLE. No new grant is made in the DONE cycle.
- Latency: ack at cycle t0, bytes issued t1..t4, DONE at t0+5+SBOX_LAT. Default SBOX_LAT=2 gives 7 cycles.
- Back-to-back throughput: one word every 6+SBOX_LAT cycles. The next ack comes one cycle after DONE.
- No preemption: a request arriving mid-word waits in IDLE until the current word completes.
- A REQ dropped before its ACK is legal: no grant, no effect.
- REQ high in the ACK cycle and again after it means a new request.
- ACK and DONE for the same side are never high together. K_DONE and R_DONE are mutually exclusive.
- RST asserted mid-word aborts it:
  - No DONE is issued.
  - In-flight S-box results are ignored (valid pipe cleared).
  - RESULT returns to 0.
- SBOX_A is 0 whenever SBOX_V=0.

Test Plan:
- Reset release, no requests -> all outputs 0, BUSY=0 indefinitely, SBOX_V never high.
- K_REQ with K_WORD=0x00010053, SBOX_LAT=2, real S-box -> K_ACK at t0; SBOX_A=0x53,0x00,0x01,0x00 at t1..t4; K_DONE at t0+7 with RESULT=0x637C63ED; R_DONE stays 0.
- K_REQ and R_REQ both high from reset, K_WORD=0xFFFFFFFF, R_WORD=0x00000000 -> K served first, RESULT=0x16161616. One idle cycle follows, then R_ACK and RESULT=0x63636363. With both held high, grants alternate K,R,K,R.
- R_REQ granted, K_REQ raised during ISSUE -> R word completes unbroken; K_ACK is the cycle after R_DONE.
- RST pulsed during DRAIN of a K word -> no K_DONE, RESULT=0, state IDLE. A K request reissued afterwards completes with the correct value.
- Sweep SBOX_LAT=1 and 4 with word 0x53535353 -> RESULT=0xEDEDEDED; DONE at t0+6 and t0+9 respectively.
